// File: rtl/line3_row_gen.sv
// line3_row_gen: turns a raster pixel stream into three vertically aligned
// rows (top/middle/bottom) for a downstream 3x3 filter. Two ping-pong row
// memories hold the previous two rows. The current row streams through as
// the bottom tap. A flush phase then emits the last row on its own.
// Optional feature: define LINEGEN_BORDER_ZERO_EN to drive zeros, instead of
// replicated rows, on the top tap of the first row and the bottom tap of the
// last row.
// Handshake: a pixel is accepted on a clk edge where pix_valid && pix_ready.
// Within a row, pixels must arrive on consecutive cycles. pix_valid while
// pix_ready=0 is a protocol error and the pixel is dropped.
module line3_row_gen #(
   parameter int DW_DEC = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DW_DEC:0]   pix_in,
   input  logic              pix_valid,
   input  logic              sof,
   output logic              pix_ready,
   output logic [DW_DEC:0]   out1,
   output logic [DW_DEC:0]   out2,
   output logic [DW_DEC:0]   out3,
   output logic              filter_start,
   output logic              filter_end,
   output logic              frame_done,
   output logic              row_err,
   output logic [1:0]        fsm_state
);

   localparam int PW = DW_DEC + 1;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
`ifdef LINEGEN_BORDER_ZERO_EN
   localparam bit BORDER_ZERO = 1'b1;
`else
   localparam bit BORDER_ZERO = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   col, col_n;
   logic [RW-1:0]   row, row_n;
   logic            wsel, wsel_n;      // bank receiving the current row
   logic            err_n;
   logic            we, w_bank;
   logic [CW-1:0]   w_addr;
   logic            emit, emit_fs, emit_fe, emit_fd;
   logic [PW-1:0]   e1, e2, e3;
   logic [PW-1:0]   rd_cur, rd_prev;  // rd_cur: row two back, rd_prev: row one back
   logic            accept;

   logic [PW-1:0]   mem0 [IMG_W];
   logic [PW-1:0]   mem1 [IMG_W];

   assign accept    = pix_valid && pix_ready;
   assign fsm_state = state;

   // Next-state, row-memory write control and output-tap selection.
   always_comb begin
      rd_cur  = wsel ? mem1[col] : mem0[col];
      rd_prev = wsel ? mem0[col] : mem1[col];
      state_n = state;
      col_n   = col;
      row_n   = row;
      wsel_n  = wsel;
      err_n   = row_err;
      we      = 1'b0;
      w_bank  = wsel;
      w_addr  = col;
      emit    = 1'b0;
      emit_fs = (col == '0);
      emit_fe = (col == COL_LAST);
      emit_fd = 1'b0;
      e1      = rd_cur;
      e2      = rd_prev;
      e3      = pix_in;
      if (pix_valid && !pix_ready) err_n = 1'b1;
      case (state)
         IDLE: begin
            if (accept && sof) begin
               err_n   = 1'b0;
               we      = 1'b1;
               w_bank  = 1'b0;
               w_addr  = '0;
               col_n   = CW'(1);
               row_n   = '0;
               wsel_n  = 1'b0;
               state_n = FILL;
            end
         end
         FILL, STREAM: begin
            if (accept && sof) begin
               // Restart: the aborted frame is dropped, this pixel opens a new one.
               err_n   = 1'b1;
               we      = 1'b1;
               w_bank  = 1'b0;
               w_addr  = '0;
               col_n   = CW'(1);
               row_n   = '0;
               wsel_n  = 1'b0;
               state_n = FILL;
            end else if (accept) begin
               we = 1'b1;
               if (state == STREAM) begin
                  emit = 1'b1;
                  if (row == ROW_ONE) e1 = BORDER_ZERO ? '0 : rd_prev;
               end
               if (col == COL_LAST) begin
                  col_n  = '0;
                  wsel_n = ~wsel;
                  if (state == FILL) begin
                     row_n   = ROW_ONE;
                     state_n = STREAM;
                  end else if (row == ROW_LAST) begin
                     state_n = FLUSH;
                  end else begin
                     row_n = row + 1'b1;
                  end
               end else begin
                  col_n = col + 1'b1;
               end
            end else if (!pix_valid && col != '0) begin
               err_n = 1'b1;
            end
         end
         FLUSH: begin
            emit = 1'b1;
            e3   = BORDER_ZERO ? '0 : rd_prev;
            if (col == COL_LAST) begin
               emit_fd = 1'b1;
               col_n   = '0;
               row_n   = '0;
               state_n = IDLE;
            end else begin
               col_n = col + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counters, error flag and ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         wsel      <= 1'b0;
         row_err   <= 1'b0;
         pix_ready <= 1'b0;
      end else begin
         state     <= state_n;
         col       <= col_n;
         row       <= row_n;
         wsel      <= wsel_n;
         row_err   <= err_n;
         pix_ready <= (state_n != FLUSH);
      end
   end

   // Registered output taps. Outside the emit window the data holds and the markers stay low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1         <= '0;
         out2         <= '0;
         out3         <= '0;
         filter_start <= 1'b0;
         filter_end   <= 1'b0;
         frame_done   <= 1'b0;
      end else if (emit) begin
         out1         <= e1;
         out2         <= e2;
         out3         <= e3;
         filter_start <= emit_fs;
         filter_end   <= emit_fe;
         frame_done   <= emit_fd;
      end else begin
         filter_start <= 1'b0;
         filter_end   <= 1'b0;
         frame_done   <= 1'b0;
      end
   end

   // Row memory write port. Each read happens in the same cycle, before the write.
   always_ff @(posedge clk) begin
      if (we) begin
         if (w_bank) mem1[w_addr] <= pix_in;
         else        mem0[w_addr] <= pix_in;
      end
   end

endmodule

// File: tb/tb_line3_row_gen.sv
// Testbench for line3_row_gen using a 4x3 frame. A table holds the reference
// frame with its expected outputs, one cycle later. Hand-written sequences
// cover gaps, errors, abort and reset-in-flush.
module tb_line3_row_gen;

   localparam int DW_DEC = 8;
   localparam int PW     = DW_DEC + 1;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int NV     = 17;
`ifdef LINEGEN_BORDER_ZERO_EN
   localparam bit BZ = 1'b1;
`else
   localparam bit BZ = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          sof = 1'b0;
   logic          pix_ready;
   logic [PW-1:0] out1, out2, out3;
   logic          filter_start, filter_end, frame_done, row_err;
   logic [1:0]    fsm_state;

   line3_row_gen #(.DW_DEC(DW_DEC), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .pix_ready(pix_ready), .out1(out1), .out2(out2), .out3(out3),
      .filter_start(filter_start), .filter_end(filter_end), .frame_done(frame_done),
      .row_err(row_err), .fsm_state(fsm_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [PW-1:0] o1, o2, o3;
      logic fs, fe, fd, err, rdy;
   } exp_t;

   typedef struct {
      logic          pv, sof;
      logic [PW-1:0] pix;
      logic          hold;
      logic [PW-1:0] o1, o2, o3;
      logic          fs, fe, fd, rdy;
   } vec_t;

   vec_t          tbl [NV];
   exp_t          exp_q [$];
   int            checks = 0;
   int            errors = 0;
   string         test_name = "reset";
   logic [PW-1:0] last_o1 = '0, last_o2 = '0, last_o3 = '0;
   logic          exp_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s [%s]: got %h expected %h", name, test_name, act, expv);
      end
   endtask

   function automatic logic [PW-1:0] bz(input int v);
      return BZ ? '0 : PW'(v);
   endfunction

   task automatic set_vec(input int i, input int pv, input int s, input int pix, input int hold,
                          input logic [PW-1:0] o1, input logic [PW-1:0] o2, input logic [PW-1:0] o3,
                          input int fs, input int fe, input int fd, input int rdy);
      tbl[i].pv = pv[0];  tbl[i].sof = s[0]; tbl[i].pix = PW'(pix); tbl[i].hold = hold[0];
      tbl[i].o1 = o1; tbl[i].o2 = o2; tbl[i].o3 = o3;
      tbl[i].fs = fs[0]; tbl[i].fe = fe[0]; tbl[i].fd = fd[0]; tbl[i].rdy = rdy[0];
   endtask

   // scoreboard: pop one expected record per cycle, after the edge
   always @(posedge clk) begin
      exp_t e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {out1, out2, out3, filter_start, filter_end, frame_done, row_err, pix_ready};
         check("out_cycle", 32'(a), 32'(e));
      end
   end

   // driver: drive one cycle of input and push what must appear after the next edge
   task automatic drive(input logic pv, input logic s, input logic [PW-1:0] pix, input logic hold,
                        input logic [PW-1:0] o1, input logic [PW-1:0] o2, input logic [PW-1:0] o3,
                        input logic fs, input logic fe, input logic fd, input logic rdy);
      exp_t e;
      @(negedge clk);
      pix_valid = pv; sof = s; pix_in = pix;
      if (!hold) begin
         last_o1 = o1; last_o2 = o2; last_o3 = o3;
      end
      e.o1 = last_o1; e.o2 = last_o2; e.o3 = last_o3;
      e.fs = fs; e.fe = fe; e.fd = fd; e.err = exp_err; e.rdy = rdy;
      exp_q.push_back(e);
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, '0, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // apply table records first..last; optional idle gap before record gap_at
   task automatic run_frame(input int first, input int last, input int gap_at, input int gap_len,
                            input logic gap_err, input logic poke);
      logic          pv_i;
      logic [PW-1:0] pix_i;
      for (int i = first; i <= last; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               if (gap_err) exp_err = 1'b1;
               idle_cycle();
            end
         end
         if (i == 0) exp_err = 1'b0;
         pv_i  = tbl[i].pv;
         pix_i = tbl[i].pix;
         if (poke && i == 13) begin
            pv_i = 1'b1; pix_i = PW'(99); exp_err = 1'b1;
         end
         drive(pv_i, tbl[i].sof, pix_i, tbl[i].hold, tbl[i].o1, tbl[i].o2, tbl[i].o3,
               tbl[i].fs, tbl[i].fe, tbl[i].fd, tbl[i].rdy);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // rows A=1..4, B=5..8, C=9..12; expectations apply after the edge
      set_vec(0,  1, 1,  1, 1, 0, 0, 0,  0, 0, 0, 1);
      set_vec(1,  1, 0,  2, 1, 0, 0, 0,  0, 0, 0, 1);
      set_vec(2,  1, 0,  3, 1, 0, 0, 0,  0, 0, 0, 1);
      set_vec(3,  1, 0,  4, 1, 0, 0, 0,  0, 0, 0, 1);
      set_vec(4,  1, 0,  5, 0, bz(1), 9'd1, 9'd5,  1, 0, 0, 1);
      set_vec(5,  1, 0,  6, 0, bz(2), 9'd2, 9'd6,  0, 0, 0, 1);
      set_vec(6,  1, 0,  7, 0, bz(3), 9'd3, 9'd7,  0, 0, 0, 1);
      set_vec(7,  1, 0,  8, 0, bz(4), 9'd4, 9'd8,  0, 1, 0, 1);
      set_vec(8,  1, 0,  9, 0, 9'd1, 9'd5, 9'd9,   1, 0, 0, 1);
      set_vec(9,  1, 0, 10, 0, 9'd2, 9'd6, 9'd10,  0, 0, 0, 1);
      set_vec(10, 1, 0, 11, 0, 9'd3, 9'd7, 9'd11,  0, 0, 0, 1);
      set_vec(11, 1, 0, 12, 0, 9'd4, 9'd8, 9'd12,  0, 1, 0, 0);
      set_vec(12, 0, 0,  0, 0, 9'd5, 9'd9,  bz(9),  1, 0, 0, 0);
      set_vec(13, 0, 0,  0, 0, 9'd6, 9'd10, bz(10), 0, 0, 0, 0);
      set_vec(14, 0, 0,  0, 0, 9'd7, 9'd11, bz(11), 0, 0, 0, 0);
      set_vec(15, 0, 0,  0, 0, 9'd8, 9'd12, bz(12), 0, 1, 1, 1);
      set_vec(16, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 1);

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs", 32'({out1, out2, out3, filter_start, filter_end, frame_done, row_err, pix_ready}), 32'd0);
      check("reset_state", 32'(fsm_state), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", 32'(pix_ready), 32'd1);

      test_name = "basic_frame";
      run_frame(0, NV-1, -1, 0, 1'b0, 1'b0);
      test_name = "gap10_between_rows";
      run_frame(0, NV-1, 4, 10, 1'b0, 1'b0);
      test_name = "random_gap_row_c";
      run_frame(0, NV-1, 8, int'($urandom_range(1, 6)), 1'b0, 1'b0);
      test_name = "gap_mid_row_b";
      run_frame(0, NV-1, 6, 1, 1'b1, 1'b0);
      idle_cycle(); idle_cycle();
      test_name = "err_cleared_by_sof";
      run_frame(0, NV-1, -1, 0, 1'b0, 1'b0);
      test_name = "valid_during_flush";
      run_frame(0, NV-1, -1, 0, 1'b0, 1'b1);

      // sof in the middle of row B aborts; the next full frame is normal
      test_name = "abort_frame";
      run_frame(0, 4, -1, 0, 1'b0, 1'b0);
      exp_err = 1'b1;
      drive(1'b1, 1'b1, 9'd1, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #2;
      check("abort_state_fill", 32'(fsm_state), 32'd1);
      run_frame(1, NV-1, -1, 0, 1'b0, 1'b0);
      drain();

      // reset during flush
      test_name = "reset_in_flush";
      run_frame(0, 13, -1, 0, 1'b0, 1'b0);
      drain();
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("flush_reset_outs", 32'({out1, out2, out3, filter_start, filter_end, frame_done, row_err, pix_ready}), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("flush_reset_no_done", 32'({frame_done, filter_start, filter_end}), 32'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      last_o1 = '0; last_o2 = '0; last_o3 = '0; exp_err = 1'b0;
      @(posedge clk); #1;
      check("flush_reset_ready", 32'(pix_ready), 32'd1);
      test_name = "frame_after_reset";
      run_frame(0, NV-1, -1, 0, 1'b0, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
